// File: rtl/pc_redirect_ctrl_pkg.sv
// pc_redirect_ctrl_pkg
//   Shared types and constants for the PC redirect controller:
//   next-PC select encoding, EX-stage instruction class, the opcodes that
//   can redirect fetch, the FSM state type and the ID-opcode decoder.
package pc_redirect_ctrl_pkg;

  // Next-PC mux select, as seen by the PC mux outside this block.
  typedef enum logic [1:0] {
    SEL_PC4 = 2'b00,  // sequential fetch
    SEL_JAL = 2'b01,  // JAL target computed in ID
    SEL_BR  = 2'b10,  // branch target computed in EX
    SEL_ALU = 2'b11   // ALU result (JALR target) in EX
  } pc_sel_t;

  // Class of the instruction currently sitting in EX.
  typedef enum logic [1:0] {
    EX_NONE   = 2'b00,
    EX_BRANCH = 2'b01,
    EX_JALR   = 2'b10
  } ex_class_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int CNT_WIDTH = 16;

  // Classify an ID-stage opcode for the EX-class register.
  function automatic ex_class_t decode_ex_class(input logic [6:0] op);
    ex_class_t cls;
    cls = EX_NONE;
    if (op == OP_BRANCH) cls = EX_BRANCH;
    else if (op == OP_JALR) cls = EX_JALR;
    return cls;
  endfunction

endpackage

// File: rtl/pc_redirect_ctrl_sat_counter.sv
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//   Ports:
//     clk   - clock, rising edge
//     reset - synchronous, active-low; clears the count
//     inc   - add one this cycle (ignored once saturated)
//     cnt   - current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] cnt
);

  logic [WIDTH-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (inc && (r_cnt != {WIDTH{1'b1}})) begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

  assign cnt = r_cnt;

endmodule

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl
//   Chooses the next PC source and kills wrong-path instructions when a
//   JAL (ID), JALR (EX) or taken branch (EX) redirects fetch. If fetch is
//   not ready, the redirect is parked in HOLD with ID/EX frozen until it is.
//   Ports:
//     clk, reset          - clock / synchronous active-low reset
//     opcode_id_i         - opcode of the instruction in ID
//     branch_taken_ex_i   - condition result of the B-type in EX
//     stall_i             - hazard stall (freeze IF/ID, bubble into EX)
//     if_ready_i          - fetch accepts a new PC this cycle
//     pc_next_sel_o       - next-PC select (see pc_sel_t)
//     pc_en_o             - PC load enable
//     if_id_flush_o       - kill IF/ID
//     id_ex_flush_o       - kill ID/EX
//     hold_o              - freeze ID and EX while a redirect waits for fetch
//     redirect_cnt_o      - saturating count of completed redirects
//
//   Handshake: a redirect is a request towards fetch; it completes in the
//   cycle pc_en_o=1 is driven while if_ready_i=1. Until then the select and
//   flush kind are kept stable and hold_o=1; no flush is issued early.
import pc_redirect_ctrl_pkg::*;

module pc_redirect_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  opcode_id_i,
  input  logic        branch_taken_ex_i,
  input  logic        stall_i,
  input  logic        if_ready_i,
  output logic [1:0]  pc_next_sel_o,
  output logic        pc_en_o,
  output logic        if_id_flush_o,
  output logic        id_ex_flush_o,
  output logic        hold_o,
  output logic [15:0] redirect_cnt_o
);

  state_t    r_state;
  state_t    w_state_nxt;
  ex_class_t r_ex_class;
  pc_sel_t   r_sel_lat;
  logic      r_ex_flush_lat;

  logic      w_ex_redir;
  logic      w_id_redir;
  logic      w_redir;
  pc_sel_t   w_req_sel;
  logic      w_stall_eff;

  pc_sel_t   w_sel;
  logic      w_pc_en;
  logic      w_if_id_flush;
  logic      w_id_ex_flush;
  logic      w_hold;

  // Redirect requests. EX wins over ID; an ID JAL also needs the ID stage
  // to be advancing (not stalled).
  always_comb begin
    w_ex_redir = (r_ex_class == EX_JALR) ||
                 ((r_ex_class == EX_BRANCH) && branch_taken_ex_i);
    w_id_redir = (opcode_id_i == OP_JAL) && !stall_i && !w_ex_redir;
    w_redir    = w_ex_redir || w_id_redir;
    if (r_ex_class == EX_JALR) w_req_sel = SEL_ALU;
    else if (w_ex_redir)       w_req_sel = SEL_BR;
    else                       w_req_sel = SEL_JAL;
  end

  // The hazard stall has no effect while a redirect is parked.
  assign w_stall_eff = stall_i && (r_state == ST_IDLE);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_redir && !if_ready_i) w_state_nxt = ST_HOLD;
      ST_HOLD: if (if_ready_i)             w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. Everything is forced quiet while reset is asserted.
  always_comb begin
    w_sel         = SEL_PC4;
    w_pc_en       = 1'b0;
    w_if_id_flush = 1'b0;
    w_id_ex_flush = 1'b0;
    w_hold        = 1'b0;
    if (reset) begin
      case (r_state)
        ST_IDLE: begin
          if (w_redir) begin
            w_sel = w_req_sel;
            if (if_ready_i) begin
              w_pc_en       = 1'b1;
              w_if_id_flush = 1'b1;
              w_id_ex_flush = w_ex_redir;
            end else begin
              w_hold = 1'b1;
            end
          end else begin
            w_pc_en = if_ready_i && !stall_i;
          end
        end
        ST_HOLD: begin
          w_sel = r_sel_lat;
          if (if_ready_i) begin
            w_pc_en       = 1'b1;
            w_if_id_flush = 1'b1;
            w_id_ex_flush = r_ex_flush_lat;
          end else begin
            w_hold = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Park the select and the flush kind when fetch refuses a redirect.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sel_lat      <= SEL_PC4;
      r_ex_flush_lat <= 1'b0;
    end else if ((r_state == ST_IDLE) && w_redir && !if_ready_i) begin
      r_sel_lat      <= w_req_sel;
      r_ex_flush_lat <= w_ex_redir;
    end
  end

  // EX-class tracks what moves ID->EX; stalls and ID/EX flushes insert a
  // bubble, hold freezes EX so the parked redirect's source stays put.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_ex_class <= EX_NONE;
    end else if (w_hold) begin
      r_ex_class <= r_ex_class;
    end else if (!w_stall_eff && !w_id_ex_flush) begin
      r_ex_class <= decode_ex_class(opcode_id_i);
    end else begin
      r_ex_class <= EX_NONE;
    end
  end

  sat_counter #(
    .WIDTH(CNT_WIDTH)
  ) u_redirect_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (w_pc_en && (w_sel != SEL_PC4)),
    .cnt   (redirect_cnt_o)
  );

  assign pc_next_sel_o = w_sel;
  assign pc_en_o       = w_pc_en;
  assign if_id_flush_o = w_if_id_flush;
  assign id_ex_flush_o = w_id_ex_flush;
  assign hold_o        = w_hold;

endmodule

// File: doc/pc_redirect_ctrl.md
PC_REDIRECT_CTRL -- requirements
Module: pc_redirect_ctrl

Interface
REQ-001 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have port reset  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port opcode_id_i  input  7  opcode of instruction in ID.
REQ-004 SHALL have port branch_taken_ex_i  input  1  condition result of B-type in EX (1 = taken).
REQ-005 SHALL have port stall_i  input  1  hazard-unit stall: freeze IF/ID, bubble into EX.
REQ-006 SHALL have port if_ready_i  input  1  fetch unit accepts a new PC this cycle.
REQ-007 SHALL have port pc_next_sel_o  output  2  00 = PC+4, 01 = JAL target (ID), 10 = branch target (EX), 11 = ALU result (JALR in EX).
REQ-008 SHALL have port pc_en_o  output  1  PC register load enable.
REQ-009 SHALL have port if_id_flush_o  output  1  kill IF/ID register contents.
REQ-010 SHALL have port id_ex_flush_o  output  1  kill ID/EX register contents.
REQ-011 SHALL have port hold_o  output  1  freeze ID and EX while a redirect waits for fetch.
REQ-012 SHALL have port redirect_cnt_o  output  16  completed-redirect count, saturating.

Function
REQ-013 SHALL keep an EX-class register (NONE, BRANCH, JALR), loaded from opcode_id_i (1100011 -> BRANCH, 1100111 -> JALR, else NONE) when stall_i=0, hold_o=0 and id_ex_flush_o=0; loaded NONE otherwise except held unchanged while hold_o=1.
REQ-014 SHALL request an EX redirect when EX-class = JALR (sel 11) or EX-class = BRANCH with branch_taken_ex_i=1 (sel 10).
REQ-015 SHALL request an ID redirect (sel 01) when opcode_id_i = 1101111, stall_i=0 and no EX redirect is requested.
REQ-016 SHALL give EX redirect priority over ID redirect; JAL in ID with JALR in EX yields sel 11, JAL in ID with BRANCH in EX yields sel 11 only if EX is JALR, sel 10 if taken branch.
REQ-017 SHALL implement FSM states IDLE, HOLD.
REQ-018 IDLE, redirect requested, if_ready_i=1: same cycle (zero latency) drive sel, pc_en_o=1; EX redirect -> if_id_flush_o=1 and id_ex_flush_o=1; ID redirect -> if_id_flush_o=1 only; stay IDLE.
REQ-019 IDLE, redirect requested, if_ready_i=0: pc_en_o=0, no flush, hold_o=1, latch sel and flush kind, go HOLD next cycle.
REQ-020 HOLD: drive latched sel, hold_o=1 while if_ready_i=0; on if_ready_i=1 assert pc_en_o=1 with latched flushes, hold_o=0, return IDLE next cycle.
REQ-021 IDLE, no redirect: sel 00, pc_en_o = if_ready_i and not stall_i, flushes 0, hold_o 0.
REQ-022 EX redirect SHALL override stall_i (ID instruction is flushed regardless).
REQ-023 stall_i and new redirect requests SHALL be ignored in HOLD.
REQ-024 redirect_cnt_o SHALL increment by 1 in each cycle pc_en_o=1 with sel != 00, saturating at 16'hFFFF (no wrap).

Reset
REQ-025 When reset=0 at a clock edge: FSM -> IDLE, EX-class -> NONE, latched sel -> 00, redirect_cnt_o -> 0, including when in HOLD (pending redirect discarded).
REQ-026 During reset outputs SHALL be sel 00, pc_en_o 0, flushes 0, hold_o 0.

Structure
REQ-027 Shared package SHALL hold pc_sel_t (2-bit enum), ex_class_t enum, opcode constants OP_JAL, OP_JALR, OP_BRANCH, and the FSM state typedef.
REQ-028 Saturating counter SHALL be a sub-module sat_counter (parameter WIDTH=16, inc input, synchronous active-low reset).

Verification
REQ-029 JALR in EX (opcode 1100111 previous cycle), JAL in ID, if_ready=1 -> sel 11, pc_en 1, both flushes 1, cnt 0->1.
REQ-030 JAL in ID, EX-class NONE, if_ready=1 -> sel 01, if_id_flush 1, id_ex_flush 0.
REQ-031 Taken branch in EX, if_ready=0 for 3 cycles then 1 -> hold_o 1 for 3 cycles, sel 10 held, pc_en 1 on 4th cycle with both flushes, then IDLE.
REQ-032 reset=0 asserted during HOLD -> next cycle IDLE, sel 00, hold_o 0, cnt 0, no pc_en.
REQ-033 Counter preloaded to 16'hFFFE via 2 extra... forced sequence of redirects -> reaches 16'hFFFF and stays at 16'hFFFF on further redirects.
REQ-034 Not-taken branch in EX with stall_i=1 -> sel 00, pc_en 0, no flush, EX-class NONE next cycle.
